// File: rtl/divisor_pkg.sv
// Shared definitions for the multi-step restoring divider: FSM states,
// latency helper and parameter legality check.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Clocks from the accepting edge to the done pulse, counting that edge as one.
  function automatic int latencia(input int size, input int steps);
    return size / steps + 3;
  endfunction

  function automatic bit steps_legal(input int steps);
    return (steps == 1) || (steps == 2) || (steps == 4);
  endfunction

endpackage

// File: rtl/divisor_paso.sv
// One combinational restoring-division step: shift in a dividend bit and
// subtract the divisor when it fits.
module divisor_paso #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] rem_in,
  input  logic            dvd_bit,
  input  logic [SIZE-1:0] divisor,
  output logic [SIZE-1:0] rem_out,
  output logic            q_bit
);

  logic [SIZE:0] shifted;
  logic [SIZE:0] diff;

  // rem_in < divisor keeps shifted < 2*divisor, so the borrow alone decides the bit
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[SIZE];
    rem_out = q_bit ? diff[SIZE-1:0] : shifted[SIZE-1:0];
  end

endmodule

// File: rtl/divisor_multipaso.sv
// Sequential signed/unsigned integer divider retiring STEPS_PER_CYCLE
// quotient bits per clock behind a start/done handshake.
module divisor_multipaso
  import divisor_pkg::*;
#(
  parameter int SIZE            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [SIZE-1:0] numerador,
  input  logic [SIZE-1:0] denominador,
  output logic [SIZE-1:0] cociente,
  output logic [SIZE-1:0] resto,
  output logic            done,
  output logic            busy,
  output logic            div_by_zero
);

  localparam int N  = SIZE / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  if (!steps_legal(STEPS_PER_CYCLE) || (SIZE % STEPS_PER_CYCLE) != 0 || SIZE < 4) begin : g_param_check
    $error("divisor_multipaso: illegal SIZE/STEPS_PER_CYCLE combination");
  end

  state_t          state;
  logic [SIZE-1:0] dvd;
  logic [SIZE-1:0] dsr;
  logic [SIZE-1:0] rem;
  logic [CW-1:0]   cnt;
  logic            sign_q;
  logic            sign_r;
  logic            zero;

  logic            num_neg;
  logic            den_neg;
  logic [SIZE-1:0] num_abs;
  logic [SIZE-1:0] den_abs;

  logic [SIZE-1:0]            rem_chain [STEPS_PER_CYCLE+1];
  logic [STEPS_PER_CYCLE-1:0] q_bits;

  always_comb begin
    num_neg = signed_mode & numerador[SIZE-1];
    den_neg = signed_mode & denominador[SIZE-1];
    num_abs = num_neg ? -numerador : numerador;
    den_abs = den_neg ? -denominador : denominador;
  end

  assign rem_chain[0] = rem;

  // dvd doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom
  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_paso
    divisor_paso #(.SIZE(SIZE)) u_paso (
      .rem_in  (rem_chain[g]),
      .dvd_bit (dvd[SIZE-1-g]),
      .divisor (dsr),
      .rem_out (rem_chain[g+1]),
      .q_bit   (q_bits[STEPS_PER_CYCLE-1-g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero        <= 1'b0;
      cociente    <= '0;
      resto       <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            rem    <= '0;
            cnt    <= '0;
            dsr    <= den_abs;
            sign_q <= num_neg ^ den_neg;
            sign_r <= num_neg;
            if (denominador == '0) begin
              zero  <= 1'b1;
              dvd   <= numerador;
              state <= FIX;
            end else begin
              zero  <= 1'b0;
              dvd   <= num_abs;
              state <= ITER;
            end
          end
        end
        ITER: begin
          rem <= rem_chain[STEPS_PER_CYCLE];
          dvd <= (dvd << STEPS_PER_CYCLE) | SIZE'(q_bits);
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero) begin
            cociente    <= '1;
            resto       <= dvd;
            div_by_zero <= 1'b1;
          end else begin
            cociente    <= sign_q ? -dvd : dvd;
            resto       <= sign_r ? -rem : rem;
            div_by_zero <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_multipaso.sv
// Bench for divisor_multipaso: two instances (1 and 4 steps per cycle) share
// stimulus and are checked against an arithmetic reference model.
module tb_divisor_multipaso;

  localparam int SIZE = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            signed_mode = 1'b0;
  logic [SIZE-1:0] numerador = '0;
  logic [SIZE-1:0] denominador = '0;

  logic [SIZE-1:0] c1, r1, c4, r4;
  logic            done1, busy1, z1, done4, busy4, z4;

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  divisor_multipaso #(.SIZE(SIZE), .STEPS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .numerador(numerador), .denominador(denominador),
    .cociente(c1), .resto(r1), .done(done1), .busy(busy1), .div_by_zero(z1)
  );

  divisor_multipaso #(.SIZE(SIZE), .STEPS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .numerador(numerador), .denominador(denominador),
    .cociente(c4), .resto(r4), .done(done4), .busy(busy4), .div_by_zero(z4)
  );

  function automatic void ref_div(input bit sm, input logic [31:0] n, input logic [31:0] d,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint nn, dd, qq, rr;
    if (d == 32'd0) begin
      q = '1; r = n; z = 1'b1;
      return;
    end
    z = 1'b0;
    if (sm) begin
      nn = longint'($signed(n));
      dd = longint'($signed(d));
    end else begin
      nn = longint'(n);
      dd = longint'(d);
    end
    qq = nn / dd;
    rr = nn % dd;
    q = qq[31:0];
    r = rr[31:0];
  endfunction

  // Starts one operation on both instances and collects what each reports.
  task automatic run_op(input bit sm, input logic [31:0] n, input logic [31:0] d,
                        output logic [31:0] q1, output logic [31:0] rr1, output logic zz1,
                        output logic [31:0] q4, output logic [31:0] rr4, output logic zz4,
                        output int lat1, output int lat4, output int bsy1, output int bsy4);
    int k;
    q1 = 'x; rr1 = 'x; zz1 = 1'bx; q4 = 'x; rr4 = 'x; zz4 = 1'bx;
    lat1 = -1; lat4 = -1; bsy1 = 0; bsy4 = 0;
    @(negedge clk);
    signed_mode = sm; numerador = n; denominador = d; start = 1'b1;
    @(posedge clk);
    k = 1;
    @(negedge clk);
    start = 1'b0;
    numerador = $urandom;
    denominador = $urandom;
    while (k < 80 && (lat1 < 0 || lat4 < 0)) begin
      if (lat1 < 0) begin
        if (done1) begin lat1 = k; q1 = c1; rr1 = r1; zz1 = z1; end
        else if (busy1) bsy1++;
      end
      if (lat4 < 0) begin
        if (done4) begin lat4 = k; q4 = c4; rr4 = r4; zz4 = z4; end
        else if (busy4) bsy4++;
      end
      if (lat1 < 0 || lat4 < 0) begin
        @(posedge clk);
        k++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({c1, r1, done1, busy1, z1} !== '0) begin
      errs++;
      $display("FAIL reset_dut1 got c=%h r=%h d=%b b=%b z=%b exp all zero", c1, r1, done1, busy1, z1);
    end
    vectors++;
    if ({c4, r4, done4, busy4, z4} !== '0) begin
      errs++;
      $display("FAIL reset_dut4 got c=%h r=%h d=%b b=%b z=%b exp all zero", c4, r4, done4, busy4, z4);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    bit          t_sm [10] = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 1};
    logic [31:0] t_n  [10] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'hFFFFFFF0, 32'd1234,
                               32'd1234, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFB2E};
    logic [31:0] t_d  [10] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'd16, 32'd0,
                               32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0};
    logic [31:0] t_q  [10] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'h0FFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFFF};
    logic [31:0] t_r  [10] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'd0, 32'd1234,
                               32'd1234, 32'd0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFB2E};
    logic        t_z  [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
    logic [31:0] q1, rr1, q4, rr4;
    logic        zz1, zz4;
    int          lat1, lat4, bsy1, bsy4, e1, e4;
    for (int i = 0; i < 10; i++) begin
      run_op(t_sm[i], t_n[i], t_d[i], q1, rr1, zz1, q4, rr4, zz4, lat1, lat4, bsy1, bsy4);
      e1 = t_z[i] ? 3 : 35;
      e4 = t_z[i] ? 3 : 11;
      vectors++;
      if ({q1, rr1, zz1} !== {t_q[i], t_r[i], t_z[i]}) begin
        errs++;
        $display("FAIL dir%0d_dut1 got q=%h r=%h z=%b exp q=%h r=%h z=%b", i, q1, rr1, zz1, t_q[i], t_r[i], t_z[i]);
      end
      vectors++;
      if ({q4, rr4, zz4} !== {t_q[i], t_r[i], t_z[i]}) begin
        errs++;
        $display("FAIL dir%0d_dut4 got q=%h r=%h z=%b exp q=%h r=%h z=%b", i, q4, rr4, zz4, t_q[i], t_r[i], t_z[i]);
      end
      vectors++;
      if (lat1 != e1 || lat4 != e4) begin
        errs++;
        $display("FAIL dir%0d_latency got %0d/%0d exp %0d/%0d", i, lat1, lat4, e1, e4);
      end
      vectors++;
      if (bsy1 != e1 - 1 || bsy4 != e4 - 1) begin
        errs++;
        $display("FAIL dir%0d_busy_cycles got %0d/%0d exp %0d/%0d", i, bsy1, bsy4, e1 - 1, e4 - 1);
      end
      @(negedge clk);
      vectors++;
      if (done1 !== 1'b0) begin
        errs++;
        $display("FAIL dir%0d_done_width got done=%b one cycle later exp 0", i, done1);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n1 = 0, n4 = 0;
    logic [31:0] q1 = 'x, rr1 = 'x, q4 = 'x, rr4 = 'x;
    @(negedge clk);
    signed_mode = 1'b0; numerador = 32'd100; denominador = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    numerador = 32'd9; denominador = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done1) begin n1++; q1 = c1; rr1 = r1; end
      if (done4) begin n4++; q4 = c4; rr4 = r4; end
      @(negedge clk);
    end
    vectors++;
    if (n1 != 1 || n4 != 1) begin
      errs++;
      $display("FAIL busy_ignore_done_count got %0d/%0d exp 1/1", n1, n4);
    end
    vectors++;
    if ({q1, rr1, q4, rr4} !== {32'd14, 32'd2, 32'd14, 32'd2}) begin
      errs++;
      $display("FAIL busy_ignore_result got %0d r %0d / %0d r %0d exp 14 r 2", q1, rr1, q4, rr4);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic [31:0] q1, rr1, q4, rr4;
    logic        zz1, zz4;
    int          lat1, lat4, bsy1, bsy4;
    @(negedge clk);
    signed_mode = 1'b0; numerador = 32'd100; denominador = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({c1, r1, done1, busy1, z1, c4, r4, done4, busy4, z4} !== '0) begin
      errs++;
      $display("FAIL reset_mid_outputs got c=%h r=%h b=%b / c=%h r=%h b=%b exp all zero", c1, r1, busy1, c4, r4, busy4);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done1 || done4) n++;
    end
    vectors++;
    if (n != 0) begin
      errs++;
      $display("FAIL reset_mid_no_done got %0d done cycles exp 0", n);
    end
    run_op(1'b0, 32'd9, 32'd3, q1, rr1, zz1, q4, rr4, zz4, lat1, lat4, bsy1, bsy4);
    vectors++;
    if ({q1, rr1, zz1, q4, rr4, zz4} !== {32'd3, 32'd0, 1'b0, 32'd3, 32'd0, 1'b0}) begin
      errs++;
      $display("FAIL reset_mid_next_op got %0d r %0d / %0d r %0d exp 3 r 0", q1, rr1, q4, rr4);
    end
  endtask

  task automatic test_back_to_back();
    int m = 0;
    @(negedge clk);
    signed_mode = 1'b0; numerador = 32'd100; denominador = 32'd7; start = 1'b1;
    while (!done1 && m < 80) begin
      @(posedge clk); m++; @(negedge clk);
    end
    vectors++;
    if (!done1 || {c1, r1} !== {32'd14, 32'd2}) begin
      errs++;
      $display("FAIL b2b_first got done=%b %0d r %0d exp done=1 14 r 2", done1, c1, r1);
    end
    numerador = 32'd9; denominador = 32'd3;
    m = 0;
    do begin
      @(posedge clk); m++; @(negedge clk);
    end while (!done1 && m < 80);
    start = 1'b0;
    vectors++;
    if (m != 35 || {c1, r1} !== {32'd3, 32'd0}) begin
      errs++;
      $display("FAIL b2b_second got gap=%0d %0d r %0d exp gap=35 3 r 0", m, c1, r1);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    bit          sm;
    logic [31:0] n, d, eq, er, q1, rr1, q4, rr4;
    logic        ez, zz1, zz4;
    int          lat1, lat4, bsy1, bsy4, sel, e1, e4;
    for (int i = 0; i < 1000; i++) begin
      sm = 1'($urandom);
      n = $urandom;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: d = 32'd0;
        1: d = 32'($urandom_range(1, 15));
        2: d = 32'hFFFFFFFF;
        3: begin n = 32'h80000000; d = 32'hFFFFFFFF; end
        default: d = $urandom >> $urandom_range(0, 31);
      endcase
      ref_div(sm, n, d, eq, er, ez);
      run_op(sm, n, d, q1, rr1, zz1, q4, rr4, zz4, lat1, lat4, bsy1, bsy4);
      e1 = ez ? 3 : 35;
      e4 = ez ? 3 : 11;
      vectors++;
      if ({q1, rr1, zz1} !== {eq, er, ez}) begin
        errs++;
        $display("FAIL rand%0d_dut1 s=%b %h/%h got q=%h r=%h z=%b exp q=%h r=%h z=%b", i, sm, n, d, q1, rr1, zz1, eq, er, ez);
      end
      vectors++;
      if ({q4, rr4, zz4} !== {eq, er, ez}) begin
        errs++;
        $display("FAIL rand%0d_dut4 s=%b %h/%h got q=%h r=%h z=%b exp q=%h r=%h z=%b", i, sm, n, d, q4, rr4, zz4, eq, er, ez);
      end
      vectors++;
      if (lat1 != e1 || lat4 != e4) begin
        errs++;
        $display("FAIL rand%0d_latency got %0d/%0d exp %0d/%0d", i, lat1, lat4, e1, e4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/divisor_multipaso.md
Name: divisor_multipaso

Overview:
Parametrised sequential integer divider, successor to the current 32-bit divisor_top.
- Adds per-operation signed/unsigned mode, a configurable radix (quotient bits retired per cycle) and a divide-by-zero flag.
- Sits behind the same start/done handshake, so the existing test_if-style benches can drive it with a wider signal set.

Parameters:
- SIZE, 32, operand/result width in bits; SIZE >= 4.
- STEPS_PER_CYCLE, 1, restoring steps per clock; one of 1, 2, 4; must divide SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  operation request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands; sampled with start.
- numerador  in  SIZE  dividend; sampled with start.
- denominador  in  SIZE  divisor; sampled with start.
- cociente  out  SIZE  quotient, registered.
- resto  out  SIZE  remainder, registered.
- done  out  1  one-cycle pulse; results valid.
- busy  out  1  high from the cycle after start is accepted until done.
- div_by_zero  out  1  registered; valid with done.

Behaviour:
- Reset (async, any state): state = IDLE; cociente, resto, done, busy, div_by_zero = 0; internal registers cleared. A mid-operation reset aborts the operation with no done pulse.
- N = SIZE/STEPS_PER_CYCLE.
- States:
  - IDLE --(start)--> ITER, or IDLE --(start & denominador==0)--> FIX.
  - ITER --(N cycles)--> FIX.
  - FIX --> DONE.
  - DONE --> IDLE.
- IDLE, start=1: latch |numerador|, |denominador| (abs only if signed_mode), sign_q = sign(num) XOR sign(den), sign_r = sign(num), mode, zero flag. Partial remainder = 0; busy=1 next cycle.
- ITER: each cycle performs STEPS_PER_CYCLE restoring steps, MSB first.
  - Per step: rem = {rem, next dividend bit}; if rem >= divisor then rem -= divisor and the quotient bit = 1.
  - Iteration counter runs 0..N-1.
- FIX: apply sign correction (negate quotient if sign_q, negate remainder if sign_r, signed mode only). Write cociente/resto/div_by_zero.
- DONE: done=1 for exactly one cycle; busy drops in the same cycle. Outputs hold until the next accepted operation's FIX.
- Latency: start sampled at edge t → done high in the cycle after edge t+N+2, i.e. N+3 clocks from start to done. For SIZE=32, STEPS=1 that is 35 cycles.
- Rounding: quotient truncates toward zero; remainder takes the dividend's sign; invariant num = q*den + r.
- Divide by zero: skip ITER (start → FIX → DONE).
  - cociente = all ones; resto = numerador (as given); div_by_zero = 1.
  - Latency 3 clocks.
- Signed overflow (MIN / -1): cociente = MIN (wraps), resto = 0, div_by_zero = 0.
- start while busy, or in FIX/DONE: ignored, no queuing. Operand changes after acceptance have no effect.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- Unsigned mode: operands are raw; MSB is data.

Decomposition:
- Package divisor_pkg:
  - state enum (IDLE, ITER, FIX, DONE).
  - function latencia(SIZE, STEPS) returning N+3.
  - constant STEPS_LEGAL check helper.
- Sub-module divisor_paso (combinational, SIZE param): one restoring step (rem_in, dividend bit, divisor → rem_out, q_bit). Instantiated STEPS_PER_CYCLE times in a generate chain.
- Top-level static assertions: SIZE % STEPS_PER_CYCLE == 0; STEPS in {1,2,4}.

Test Plan:
- SIZE=32, STEPS=1, unsigned 100/7 → cociente=14, resto=2, div_by_zero=0; done exactly 35 cycles after the start edge; busy high 34 cycles.
- Signed -100/7 → cociente=-14 (0xFFFFFFF2), resto=-2 (0xFFFFFFFE). Signed 100/-7 → -14, 2. Unsigned 0xFFFFFFF0/16 → 0x0FFFFFFF, 0.
- Divide by zero, signed or unsigned, 1234/0 → cociente=0xFFFFFFFF, resto=1234, div_by_zero=1; done 3 cycles after start.
- Signed 0x80000000/-1 → cociente=0x80000000, resto=0, div_by_zero=0.
- start pulsed with 9/3 while busy with 100/7 → ignored; single done with 14 r 2. Reset mid-ITER → no done, outputs 0; next op 9/3 → 3 r 0.
- STEPS=4: 100/7 → 14 r 2 in 11 cycles. Random 1000-vector self-checking run against a reference model for all parameter sets.
